// File: rtl/l2_cache_control.sv
// L2 cache control FSM: sequences hit / write-back / allocate, keeps per-set
// tree pseudo-LRU state and hit/miss performance counters.
module l2_cache_control #(
   parameter int unsigned NUM_SETS = 8,
   parameter int unsigned CNT_W    = 32,
   localparam int unsigned IDX_W   = $clog2(NUM_SETS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [IDX_W-1:0] set_index_i,
   input  logic             valid0_i,
   input  logic             valid1_i,
   input  logic             valid2_i,
   input  logic             valid3_i,
   input  logic             dirty0_i,
   input  logic             dirty1_i,
   input  logic             dirty2_i,
   input  logic             dirty3_i,
   input  logic             hit0_i,
   input  logic             hit1_i,
   input  logic             hit2_i,
   input  logic             hit3_i,
   input  logic             hit_any_i,
   input  logic             pmem_resp_i,
   output logic             mem_resp_o,
   output logic             idling_o,
   output logic             alloc_o,
   output logic [1:0]       lru_o,
   output logic             pmem_read_o,
   output logic             pmem_write_o,
   output logic             pmem_addr_sel_o,
   output logic             data_sel_o,
   output logic             dirty_in_o,
   output logic [CNT_W-1:0] hit_count_o,
   output logic [CNT_W-1:0] miss_count_o
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

   state_e           state_q, state_d;
   logic [2:0]       plru_q [NUM_SETS];
   logic [2:0]       plru_cur, plru_upd;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;
   logic [3:0]       valid, dirty;
   logic [1:0]       victim, hit_way;
   logic             req, idle_hit, idle_miss;

   assign valid     = {valid3_i, valid2_i, valid1_i, valid0_i};
   assign dirty     = {dirty3_i, dirty2_i, dirty1_i, dirty0_i};
   assign req       = mem_read_i | mem_write_i;
   assign idle_hit  = (state_q == StIdle) & req & hit_any_i;
   assign idle_miss = (state_q == StIdle) & req & ~hit_any_i;

   // PLRU bits: [0]=b0 (root), [1]=b1 (ways 0/1), [2]=b2 (ways 2/3)
   assign plru_cur = plru_q[set_index_i];
   assign victim   = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                                 : (plru_cur[1] ? 2'd1 : 2'd0);
   assign lru_o    = victim;

   // Multiple hits are illegal; the lowest way wins.
   always_comb begin
      hit_way = 2'd0;
      if (hit0_i)      hit_way = 2'd0;
      else if (hit1_i) hit_way = 2'd1;
      else if (hit2_i) hit_way = 2'd2;
      else if (hit3_i) hit_way = 2'd3;
   end

   always_comb begin
      plru_upd = plru_cur;
      unique case (hit_way)
         2'd0: plru_upd = {plru_cur[2], 1'b1, 1'b1};
         2'd1: plru_upd = {plru_cur[2], 1'b0, 1'b1};
         2'd2: plru_upd = {1'b1, plru_cur[1], 1'b0};
         2'd3: plru_upd = {1'b0, plru_cur[1], 1'b0};
         default: plru_upd = plru_cur;
      endcase
   end

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (idle_hit)  hit_count_d  = hit_count_q + CntOne;
      if (idle_miss) miss_count_d = miss_count_q + CntOne;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         for (int i = 0; i < NUM_SETS; i++) begin
            plru_q[i] <= 3'b000;
         end
      end else begin
         state_q      <= state_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         if (idle_hit) begin
            plru_q[set_index_i] <= plru_upd;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (idle_miss) begin
               state_d = (&valid && dirty[victim]) ? StWriteback : StAllocate;
            end
         end
         StWriteback: if (pmem_resp_i) state_d = StAllocate;
         StAllocate:  if (pmem_resp_i) state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_resp_o      = 1'b0;
      idling_o        = 1'b0;
      alloc_o         = 1'b0;
      pmem_read_o     = 1'b0;
      pmem_write_o    = 1'b0;
      pmem_addr_sel_o = 1'b0;
      data_sel_o      = 1'b0;
      dirty_in_o      = 1'b1;
      unique case (state_q)
         StIdle: begin
            idling_o   = 1'b1;
            mem_resp_o = idle_hit;
         end
         StWriteback: begin
            pmem_write_o    = 1'b1;
            pmem_addr_sel_o = 1'b1;
         end
         StAllocate: begin
            pmem_read_o = 1'b1;
            alloc_o     = 1'b1;
            data_sel_o  = 1'b1;
            dirty_in_o  = 1'b0;
         end
         default: ;
      endcase
   end

   assign hit_count_o  = hit_count_q;
   assign miss_count_o = miss_count_q;

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed self-checking bench for l2_cache_control; hit/valid/dirty inputs
// play the role of the tag arrays and enable logic.
module tb_l2_cache_control;

   logic        clk = 1'b0;
   logic        rst, mem_read, mem_write, hit_any, pmem_resp;
   logic [2:0]  set_index;
   logic [3:0]  valid, dirty, hit;
   logic        mem_resp, idling, alloc, pmem_read, pmem_write, pmem_addr_sel;
   logic        data_sel, dirty_in;
   logic [1:0]  lru;
   logic [31:0] hit_count, miss_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l2_cache_control #(.NUM_SETS(8), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
      .set_index_i(set_index),
      .valid0_i(valid[0]), .valid1_i(valid[1]), .valid2_i(valid[2]), .valid3_i(valid[3]),
      .dirty0_i(dirty[0]), .dirty1_i(dirty[1]), .dirty2_i(dirty[2]), .dirty3_i(dirty[3]),
      .hit0_i(hit[0]), .hit1_i(hit[1]), .hit2_i(hit[2]), .hit3_i(hit[3]),
      .hit_any_i(hit_any), .pmem_resp_i(pmem_resp),
      .mem_resp_o(mem_resp), .idling_o(idling), .alloc_o(alloc), .lru_o(lru),
      .pmem_read_o(pmem_read), .pmem_write_o(pmem_write),
      .pmem_addr_sel_o(pmem_addr_sel), .data_sel_o(data_sel), .dirty_in_o(dirty_in),
      .hit_count_o(hit_count), .miss_count_o(miss_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_hit(input int w);
      hit     = 4'b0000;
      hit_any = 1'b0;
      if (w >= 0) begin
         hit[w]  = 1'b1;
         hit_any = 1'b1;
      end
   endtask

   // Clean miss on idx with valid mask v; fill lands in `way`, then the retried request hits.
   task automatic fill(input logic [2:0] idx, input logic [3:0] v, input int way,
                       input logic [1:0] exp_lru);
      set_index = idx; valid = v; dirty = 4'b0000; set_hit(-1); mem_read = 1'b1;
      #1;
      chk("fill_miss_no_resp", mem_resp, 1'b0);
      tick();
      chk("fill_alloc", alloc, 1'b1);
      chk("fill_no_wb", pmem_write, 1'b0);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0; valid[way] = 1'b1; set_hit(way);
      #1;
      chk("fill_hit_resp", mem_resp, 1'b1);
      tick();
      mem_read = 1'b0; set_hit(-1);
      #1;
      chk("fill_lru", lru, exp_lru);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
      set_index = 3'd0; valid = 4'b0000; dirty = 4'b0000; set_hit(-1);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_idling", idling, 1'b1);
      chk("rst_alloc", alloc, 1'b0);
      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_write", pmem_write, 1'b0);
      chk("rst_mem_resp", mem_resp, 1'b0);
      chk("rst_lru", lru, 2'd0);
      chk("rst_dirty_in", dirty_in, 1'b1);
      chk("rst_data_sel", data_sel, 1'b0);
      chk("rst_addr_sel", pmem_addr_sel, 1'b0);
      chk("rst_hit_cnt", hit_count, 32'd0);
      chk("rst_miss_cnt", miss_count, 32'd0);

      // Read miss on set 0, pmem_resp on the third ALLOCATE cycle
      mem_read = 1'b1;
      #1;
      chk("t1_no_resp", mem_resp, 1'b0);
      tick();
      chk("t1_alloc", alloc, 1'b1);
      chk("t1_pmem_read", pmem_read, 1'b1);
      chk("t1_idling", idling, 1'b0);
      chk("t1_data_sel", data_sel, 1'b1);
      chk("t1_dirty_in", dirty_in, 1'b0);
      chk("t1_miss_cnt", miss_count, 32'd1);
      tick();
      chk("t1_alloc_c2", pmem_read, 1'b1);
      tick();
      pmem_resp = 1'b1;
      #1;
      chk("t1_read_held", pmem_read, 1'b1);
      chk("t1_no_resp_alloc", mem_resp, 1'b0);
      tick();
      pmem_resp = 1'b0; valid = 4'b0001; set_hit(0);
      #1;
      chk("t1_idle", idling, 1'b1);
      chk("t1_mem_resp", mem_resp, 1'b1);
      tick();
      mem_read = 1'b0; set_hit(-1);
      #1;
      chk("t1_hit_cnt", hit_count, 32'd1);
      chk("t1_miss_cnt2", miss_count, 32'd1);
      chk("t1_lru_set0", lru, 2'd2);

      // Fill set 2 ways 0..3 then hit way 0
      fill(3'd2, 4'b0000, 0, 2'd2);
      fill(3'd2, 4'b0001, 1, 2'd2);
      fill(3'd2, 4'b0011, 2, 2'd0);
      fill(3'd2, 4'b0111, 3, 2'd0);
      valid = 4'b1111; mem_read = 1'b1; set_hit(0);
      #1;
      chk("t2_hit_resp", mem_resp, 1'b1);
      tick();
      mem_read = 1'b0; set_hit(-1);
      #1;
      chk("t2_lru", lru, 2'd2);
      chk("t2_hit_cnt", hit_count, 32'd6);
      chk("t2_miss_cnt", miss_count, 32'd5);

      // Set 5 dirty victim (way 0): write-back, then allocate
      set_index = 3'd5; valid = 4'b1111; dirty = 4'b0001; mem_read = 1'b1;
      #1;
      chk("t3_victim", lru, 2'd0);
      tick();
      chk("t3_pmem_write", pmem_write, 1'b1);
      chk("t3_addr_sel", pmem_addr_sel, 1'b1);
      chk("t3_idling", idling, 1'b0);
      chk("t3_no_read", pmem_read, 1'b0);
      chk("t3_no_resp", mem_resp, 1'b0);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      #1;
      chk("t3_alloc", alloc, 1'b1);
      chk("t3_wb_done", pmem_write, 1'b0);
      chk("t3_addr_sel0", pmem_addr_sel, 1'b0);
      tick();
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0; dirty = 4'b0000; set_hit(0);
      #1;
      chk("t3_mem_resp", mem_resp, 1'b1);
      tick();
      mem_read = 1'b0; set_hit(-1);
      #1;
      chk("t3_lru", lru, 2'd2);
      chk("t3_miss_cnt", miss_count, 32'd6);
      chk("t3_hit_cnt", hit_count, 32'd7);

      // Set 5 clean victim (way 2): straight to ALLOCATE
      dirty = 4'b0001; mem_read = 1'b1;
      tick();
      chk("t4_alloc", alloc, 1'b1);
      chk("t4_no_wb", pmem_write, 1'b0);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0; set_hit(2);
      #1;
      chk("t4_mem_resp", mem_resp, 1'b1);
      tick();
      mem_read = 1'b0; set_hit(-1);
      #1;
      chk("t4_lru", lru, 2'd1);

      // Write hit on way 3, then hit way 1 exposes b2
      mem_write = 1'b1; set_hit(3);
      #1;
      chk("t5_mem_resp", mem_resp, 1'b1);
      chk("t5_dirty_in", dirty_in, 1'b1);
      chk("t5_data_sel", data_sel, 1'b0);
      tick();
      mem_write = 1'b0; set_hit(-1);
      #1;
      chk("t5_lru", lru, 2'd1);
      mem_read = 1'b1; set_hit(1);
      tick();
      mem_read = 1'b0; set_hit(-1);
      #1;
      chk("t5_b2_clear", lru, 2'd2);
      chk("t5_hit_cnt", hit_count, 32'd10);

      // Reset during ALLOCATE, then a stray pmem_resp
      set_index = 3'd1; valid = 4'b0000; mem_read = 1'b1;
      tick();
      chk("t6_alloc", alloc, 1'b1);
      rst = 1'b1; mem_read = 1'b0;
      tick();
      rst = 1'b0; set_index = 3'd5;
      #1;
      chk("t6_idling", idling, 1'b1);
      chk("t6_pmem_read", pmem_read, 1'b0);
      chk("t6_lru", lru, 2'd0);
      chk("t6_hit_cnt", hit_count, 32'd0);
      chk("t6_miss_cnt", miss_count, 32'd0);
      pmem_resp = 1'b1;
      #1;
      chk("t6_stray_resp", mem_resp, 1'b0);
      tick();
      pmem_resp = 1'b0;
      #1;
      chk("t6_still_idle", idling, 1'b1);
      chk("t6_no_alloc", alloc, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
